// File: rtl/dds_pdat_ramp_gen_if.sv
// dds_pdat_ramp_gen_if
//   Bundle of the ramp generator's control, configuration and sample-output
//   signals. Clock and reset stay as plain ports on the modules.
//   Signals:
//     start, abort             1-cycle control strobes
//     cfg_base, cfg_step       first sample / two's-complement increment (DW)
//     cfg_nstep                number of updates after base (CW)
//     cfg_div                  hold length minus 1 (DIVW)
//     cfg_pf, cfg_sat, cfg_tri data type, saturate enable, triangle request
//     pdat, pf, tx_en          sample output towards the DDS function input
//     busy, done               ramp status
//   Modports: master drives control/config, slave is the ramp generator.
interface dds_pdat_ramp_gen_if #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int DIVW = 8
);
  logic            start;
  logic            abort;
  logic [DW-1:0]   cfg_base;
  logic [DW-1:0]   cfg_step;
  logic [CW-1:0]   cfg_nstep;
  logic [DIVW-1:0] cfg_div;
  logic [1:0]      cfg_pf;
  logic            cfg_sat;
  logic            cfg_tri;
  logic [DW-1:0]   pdat;
  logic [1:0]      pf;
  logic            tx_en;
  logic            busy;
  logic            done;

  modport master (
    output start, abort, cfg_base, cfg_step, cfg_nstep, cfg_div,
           cfg_pf, cfg_sat, cfg_tri,
    input  pdat, pf, tx_en, busy, done
  );

  modport slave (
    input  start, abort, cfg_base, cfg_step, cfg_nstep, cfg_div,
           cfg_pf, cfg_sat, cfg_tri,
    output pdat, pf, tx_en, busy, done
  );
endinterface

// File: rtl/dds_pdat_ramp_gen.sv
// dds_pdat_ramp_gen
//   Hardware ramp source for the DDS parallel-data path. On a start strobe the
//   configuration is shadowed and a stepped pdat sequence is emitted: base,
//   then nstep updates of +step, every sample held (div+1) clocks. Results
//   either saturate at 0 / all-ones or wrap modulo 2^DW. abort returns to IDLE
//   at once without a done pulse.
//   Ports:
//     clk    system clock, posedge
//     rst_n  asynchronous active-low reset
//     bus    dds_pdat_ramp_gen_if.slave (control, config, pdat/pf/tx_en,
//            busy/done)
//   Build option:
//     DDS_RAMP_TRI_EN  adds the DOWN state; with cfg_tri=1 at start the up
//                      ramp is followed by nstep updates of -step.
//
//   state | meaning
//   IDLE  | waiting for start, outputs hold last sample
//   RUN   | emitting up-ramp samples
//   DOWN  | emitting down-ramp samples (DDS_RAMP_TRI_EN only)
//   FIN   | one-cycle done pulse, then IDLE
module dds_pdat_ramp_gen #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int DIVW = 8
) (
  input logic               clk,
  input logic               rst_n,
  dds_pdat_ramp_gen_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
`ifdef DDS_RAMP_TRI_EN
  localparam logic [1:0] DOWN = 2'd2;
`endif
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [DW-1:0]   pdat_q, pdat_d;
  logic [1:0]      pf_q, pf_d;
  logic            tx_en_q, tx_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   step_q, step_d;
  logic [CW-1:0]   nstep_q, nstep_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            sat_q, sat_d;
  logic [DIVW-1:0] hold_q, hold_d;
  logic [CW-1:0]   cnt_q, cnt_d;
`ifdef DDS_RAMP_TRI_EN
  logic            tri_mode_q, tri_mode_d;
`else
  logic            unused_cfg_tri;
  assign unused_cfg_tri = bus.cfg_tri;
`endif

  // Two guard bits: bit DW+1 flags a negative result, bit DW an overflow
  // past all-ones, so both clamp directions are unambiguous.
  logic [DW+1:0] step_sx;
  logic [DW+1:0] sum_up;
  logic [DW+1:0] sum_dn;
  logic [DW-1:0] pdat_up;
  logic [DW-1:0] pdat_dn;

  function automatic logic [DW-1:0] clamp(input logic [DW+1:0] s, input logic sat);
    logic [DW-1:0] r;
    r = s[DW-1:0];
    if (sat) begin
      if (s[DW+1])    r = '0;
      else if (s[DW]) r = '1;
    end
    return r;
  endfunction

  always_comb begin
    step_sx = {{2{step_q[DW-1]}}, step_q};
    sum_up  = {2'b00, pdat_q} + step_sx;
    sum_dn  = {2'b00, pdat_q} - step_sx;
    pdat_up = clamp(sum_up, sat_q);
    pdat_dn = clamp(sum_dn, sat_q);
  end

  logic hold_wrap;
  logic start_ok;
  assign hold_wrap = (hold_q == div_q);
  assign start_ok  = bus.start && !bus.abort;

  always_comb begin
    state_d = state_q;
    pdat_d  = pdat_q;
    pf_d    = pf_q;
    tx_en_d = tx_en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    step_d  = step_q;
    nstep_d = nstep_q;
    div_d   = div_q;
    sat_d   = sat_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
`ifdef DDS_RAMP_TRI_EN
    tri_mode_d = tri_mode_q;
`endif

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        tx_en_d = 1'b0;
        busy_d  = 1'b0;
        if (start_ok) begin
          state_d = RUN;
          step_d  = bus.cfg_step;
          nstep_d = bus.cfg_nstep;
          div_d   = bus.cfg_div;
          sat_d   = bus.cfg_sat;
`ifdef DDS_RAMP_TRI_EN
          tri_mode_d = bus.cfg_tri;
`endif
          pdat_d  = bus.cfg_base;
          pf_d    = bus.cfg_pf;
          tx_en_d = 1'b1;
          busy_d  = 1'b1;
          hold_d  = '0;
          cnt_d   = '0;
        end
      end

      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          tx_en_d = 1'b0;
          busy_d  = 1'b0;
        end else if (!hold_wrap) begin
          hold_d = hold_q + 1'b1;
        end else begin
          hold_d = '0;
          if (cnt_q < nstep_q) begin
            pdat_d = pdat_up;
            cnt_d  = cnt_q + 1'b1;
          end
`ifdef DDS_RAMP_TRI_EN
          // The first down update happens on the same wrap that ends the
          // peak sample, so the peak is held exactly div+1 cycles.
          else if (tri_mode_q && (nstep_q != '0)) begin
            state_d = DOWN;
            pdat_d  = pdat_dn;
            cnt_d   = CW'(1);
          end
`endif
          else begin
            state_d = FIN;
            tx_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

`ifdef DDS_RAMP_TRI_EN
      DOWN: begin
        if (bus.abort) begin
          state_d = IDLE;
          tx_en_d = 1'b0;
          busy_d  = 1'b0;
        end else if (!hold_wrap) begin
          hold_d = hold_q + 1'b1;
        end else begin
          hold_d = '0;
          if (cnt_q < nstep_q) begin
            pdat_d = pdat_dn;
            cnt_d  = cnt_q + 1'b1;
          end else begin
            state_d = FIN;
            tx_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = IDLE;
        tx_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pdat_q  <= '0;
      pf_q    <= '0;
      tx_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= '0;
      nstep_q <= '0;
      div_q   <= '0;
      sat_q   <= 1'b0;
      hold_q  <= '0;
      cnt_q   <= '0;
`ifdef DDS_RAMP_TRI_EN
      tri_mode_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pdat_q  <= pdat_d;
      pf_q    <= pf_d;
      tx_en_q <= tx_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      step_q  <= step_d;
      nstep_q <= nstep_d;
      div_q   <= div_d;
      sat_q   <= sat_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
`ifdef DDS_RAMP_TRI_EN
      tri_mode_q <= tri_mode_d;
`endif
    end
  end

  assign bus.pdat  = pdat_q;
  assign bus.pf    = pf_q;
  assign bus.tx_en = tx_en_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_dds_pdat_ramp_gen.sv
// tb_dds_pdat_ramp_gen
//   Directed bench for dds_pdat_ramp_gen. Inputs change on the falling edge,
//   outputs are sampled on the falling edge, expected values are hand-derived.
module tb_dds_pdat_ramp_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  dds_pdat_ramp_gen_if bus ();

  dds_pdat_ramp_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [15:0] base, input logic [15:0] step,
                         input logic [15:0] nstep, input logic [7:0] div,
                         input logic sat, input logic [1:0] pf, input logic tri_m);
    bus.cfg_base  = base;
    bus.cfg_step  = step;
    bus.cfg_nstep = nstep;
    bus.cfg_div   = div;
    bus.cfg_sat   = sat;
    bus.cfg_pf    = pf;
    bus.cfg_tri   = tri_m;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic samp(input string tag, input logic [15:0] exp);
    chk({tag, "_pdat"},  {16'h0, bus.pdat}, {16'h0, exp});
    chk({tag, "_tx_en"}, {31'h0, bus.tx_en}, 32'd1);
    chk({tag, "_busy"},  {31'h0, bus.busy}, 32'd1);
    @(negedge clk);
  endtask

  task automatic fin(input string tag, input logic [15:0] last);
    chk({tag, "_done"},     {31'h0, bus.done}, 32'd1);
    chk({tag, "_fin_tx"},   {31'h0, bus.tx_en}, 32'd0);
    chk({tag, "_fin_busy"}, {31'h0, bus.busy}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_off"}, {31'h0, bus.done}, 32'd0);
    chk({tag, "_hold"},     {16'h0, bus.pdat}, {16'h0, last});
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(16'h0, 16'h0, 16'h0, 8'h0, 1'b0, 2'b00, 1'b0);

    #1 rst_n = 1'b0;
    #1;
    chk("rst_pdat",  {16'h0, bus.pdat}, 32'h0);
    chk("rst_pf",    {30'h0, bus.pf}, 32'h0);
    chk("rst_tx_en", {31'h0, bus.tx_en}, 32'h0);
    chk("rst_busy",  {31'h0, bus.busy}, 32'h0);
    chk("rst_done",  {31'h0, bus.done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_tx_en", {31'h0, bus.tx_en}, 32'h0);

    // T1: linear ramp, div=0
    set_cfg(16'h1000, 16'h0010, 16'd3, 8'd0, 1'b0, 2'b10, 1'b0);
    start_pulse();
    chk("t1_pf", {30'h0, bus.pf}, 32'h2);
    samp("t1_s0", 16'h1000);
    samp("t1_s1", 16'h1010);
    samp("t1_s2", 16'h1020);
    samp("t1_s3", 16'h1030);
    fin("t1", 16'h1030);

    // T2: overflow, saturating then wrapping, div=1
    set_cfg(16'hFFF0, 16'h0020, 16'd2, 8'd1, 1'b1, 2'b01, 1'b0);
    start_pulse();
    samp("t2s_a0", 16'hFFF0);
    samp("t2s_a1", 16'hFFF0);
    samp("t2s_b0", 16'hFFFF);
    samp("t2s_b1", 16'hFFFF);
    samp("t2s_c0", 16'hFFFF);
    samp("t2s_c1", 16'hFFFF);
    fin("t2s", 16'hFFFF);

    set_cfg(16'hFFF0, 16'h0020, 16'd2, 8'd1, 1'b0, 2'b01, 1'b0);
    start_pulse();
    samp("t2w_a0", 16'hFFF0);
    samp("t2w_a1", 16'hFFF0);
    samp("t2w_b0", 16'h0010);
    samp("t2w_b1", 16'h0010);
    samp("t2w_c0", 16'h0030);
    samp("t2w_c1", 16'h0030);
    fin("t2w", 16'h0030);

    // T3: negative step clamps at zero
    set_cfg(16'h0100, 16'hFF00, 16'd3, 8'd0, 1'b1, 2'b00, 1'b0);
    start_pulse();
    samp("t3_s0", 16'h0100);
    samp("t3_s1", 16'h0000);
    samp("t3_s2", 16'h0000);
    samp("t3_s3", 16'h0000);
    fin("t3", 16'h0000);

    // T4: nstep=0, div=4; a start with new config mid-ramp is ignored
    set_cfg(16'h1234, 16'h0001, 16'd0, 8'd4, 1'b0, 2'b00, 1'b0);
    start_pulse();
    samp("t4_h0", 16'h1234);
    set_cfg(16'hAAAA, 16'h0100, 16'd5, 8'd0, 1'b0, 2'b11, 1'b0);
    bus.start = 1'b1;
    samp("t4_h1", 16'h1234);
    bus.start = 1'b0;
    samp("t4_h2", 16'h1234);
    samp("t4_h3", 16'h1234);
    samp("t4_h4", 16'h1234);
    chk("t4_pf_kept", {30'h0, bus.pf}, 32'h0);
    fin("t4", 16'h1234);

    // T5: abort together with start on the third sample
    set_cfg(16'h0000, 16'h0001, 16'd10, 8'd0, 1'b0, 2'b11, 1'b0);
    start_pulse();
    samp("t5_s0", 16'h0000);
    samp("t5_s1", 16'h0001);
    chk("t5_s2_pdat", {16'h0, bus.pdat}, 32'h2);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("t5_ab_tx_en", {31'h0, bus.tx_en}, 32'h0);
    chk("t5_ab_busy",  {31'h0, bus.busy}, 32'h0);
    chk("t5_ab_done",  {31'h0, bus.done}, 32'h0);
    chk("t5_ab_pdat",  {16'h0, bus.pdat}, 32'h2);
    @(negedge clk);
    chk("t5_idle_tx_en", {31'h0, bus.tx_en}, 32'h0);
    chk("t5_idle_busy",  {31'h0, bus.busy}, 32'h0);
    chk("t5_idle_done",  {31'h0, bus.done}, 32'h0);
    chk("t5_idle_pdat",  {16'h0, bus.pdat}, 32'h2);

    // T5b: asynchronous reset mid-ramp, checked between clock edges
    start_pulse();
    samp("t5r_s0", 16'h0000);
    samp("t5r_s1", 16'h0001);
    chk("t5r_pf_pre", {30'h0, bus.pf}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5r_pdat",  {16'h0, bus.pdat}, 32'h0);
    chk("t5r_pf",    {30'h0, bus.pf}, 32'h0);
    chk("t5r_tx_en", {31'h0, bus.tx_en}, 32'h0);
    chk("t5r_busy",  {31'h0, bus.busy}, 32'h0);
    chk("t5r_done",  {31'h0, bus.done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T6: triangle request
    set_cfg(16'h0000, 16'h0001, 16'd2, 8'd0, 1'b0, 2'b00, 1'b1);
    start_pulse();
    samp("t6_s0", 16'h0000);
    samp("t6_s1", 16'h0001);
    samp("t6_s2", 16'h0002);
`ifdef DDS_RAMP_TRI_EN
    samp("t6_s3", 16'h0001);
    samp("t6_s4", 16'h0000);
    fin("t6", 16'h0000);
`else
    fin("t6", 16'h0002);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
